// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART RX with a valid/ready holding register
// Optional feature macro: UART_RX_PARITY_EN adds one parity bit after the data bits.
// Ports:
//   clk         system clock, all logic on posedge
//   reset       synchronous active-high reset
//   s_tick      1-cycle oversampling pulse, 16 per bit
//   rx          asynchronous serial line, idles high
//   rx_data     received byte, stable while rx_valid = 1
//   rx_valid    holding register full
//   rx_ready    consumer takes the byte when rx_valid && rx_ready
//   frame_err   1-cycle pulse, stop bit sampled low
//   overrun_err 1-cycle pulse, frame completed while the holding register was full
//   parity_err  1-cycle pulse, parity mismatch (0 without UART_RX_PARITY_EN)
module uart_receiver #(
    parameter int DBITS      = 8,
    parameter int SB_TICKS   = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_tick,
    input  logic             rx,
    output logic [DBITS-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             frame_err,
    output logic             overrun_err,
    output logic             parity_err
);
    localparam int NW = $clog2(DBITS);

    if (DBITS < 5 || DBITS > 9 || SB_TICKS < 16 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_receiver: unsupported parameter value");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state_q;
    logic [1:0]       sync_q;
    logic             rx_s;
    logic             armed_q;
    logic [5:0]       t_q;
    logic [NW-1:0]    n_q;
    logic [DBITS-1:0] sr_q;
    logic [DBITS-1:0] data_q;
    logic             valid_q;
    logic             ferr_q;
    logic             oerr_q;

    assign rx_s        = sync_q[1];
    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;

`ifdef UART_RX_PARITY_EN
    logic par_q;
    logic perr_q;
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            armed_q <= 1'b1;
            t_q     <= '0;
            n_q     <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            sync_q <= {sync_q[0], rx};
            ferr_q <= 1'b0;
            oerr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
            // A new start needs the line to have been seen high first, so a break does not retrigger
            if (rx_s)
                armed_q <= 1'b1;
            if (valid_q && rx_ready)
                valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s && armed_q) begin
                        state_q <= START;
                        t_q     <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (t_q == 6'd7) begin
                            t_q     <= '0;
                            n_q     <= '0;
                            state_q <= rx_s ? IDLE : DATA;
                        end else
                            t_q <= t_q + 1'b1;
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (t_q == 6'd15) begin
                            t_q  <= '0;
                            sr_q <= {rx_s, sr_q[DBITS-1:1]};
                            if (n_q == NW'(DBITS - 1))
`ifdef UART_RX_PARITY_EN
                                state_q <= PARITY;
`else
                                state_q <= STOP;
`endif
                            else
                                n_q <= n_q + 1'b1;
                        end else
                            t_q <= t_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (s_tick) begin
                        if (t_q == 6'd15) begin
                            t_q     <= '0;
                            par_q   <= rx_s;
                            state_q <= STOP;
                        end else
                            t_q <= t_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (s_tick) begin
                        if (t_q == 6'(SB_TICKS - 1)) begin
                            t_q     <= '0;
                            state_q <= IDLE;
                            if (!rx_s) begin
                                ferr_q  <= 1'b1;
                                armed_q <= 1'b0;
                            end else begin
                                // Acceptance in this same cycle frees the register for the new byte
                                if (valid_q && !rx_ready)
                                    oerr_q <= 1'b1;
                                else begin
                                    data_q  <= sr_q;
                                    valid_q <= 1'b1;
                                end
`ifdef UART_RX_PARITY_EN
                                perr_q <= (^sr_q ^ 1'(PARITY_ODD)) != par_q;
`endif
                            end
                        end else
                            t_q <= t_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
